awg_instr_sequencer: RTL and testbench
======================================

// Module: awg_instr_sequencer
// PURPOSE
//  Walks a host-loaded table of 128-bit waveform instructions and feeds PLAY entries, one at a time, to descriptor_generator.
//  Sits between the host register/config interface and descriptor_generator.
//  Handles one JUMP/loop level and program END; reports busy/done/error to the host.
// PARAMETERS
//  DEPTH    256  instruction table entries (power of 2)
//  ADDR_W   8    log2(DEPTH); table address / program counter width
// PORTS
//  clk            in   1       clock
//  rstn           in   1       reset, asynchronous, active-low
//  tbl_wr_en      in   1       host table write strobe
//  tbl_wr_addr    in   ADDR_W  host table write address
//  tbl_wr_data    in   128     host table write data
//  start          in   1       pulse: run program from entry 0
//  abort          in   1       pulse: stop after the in-flight descriptor completes
//  busy           out  1       program running, including drain
//  done           out  1       1-cycle pulse: END reached, or abort drain finished
//  err            out  1       sticky error flag; cleared by start
//  instrcution    out  128     instruction to descriptor_generator; registered, held stable
//  instrc_valid   out  1       1-cycle issue pulse to descriptor_generator
//  generate_done  in   1       descriptor_generator pre-completion pulse
//  desc_gen_last  in   1       descriptor_generator level: instruction finished
// BEHAVIOUR
//  Reset: busy=0, done=0, err=0, instrc_valid=0, instrcution=0, pc=0, loop_cnt=0, state=IDLE.
//  Opcode field [3:0]: 1=PLAY, 2=JUMP, 3=END; any other value is illegal.
//  PLAY fields: [96:64] addr, [57:32] length, [19:4] segment_times.
//  JUMP fields: [43:32] target (low ADDR_W bits used), [19:4] repeat count N.
//  FSM:
//   IDLE    start -> FETCH (pc=0, err=0).
//   FETCH   table read, 1-cycle latency -> DECODE.
//   DECODE  PLAY with segment_times!=0 -> ISSUE.
//           PLAY with segment_times==0 -> err=1, done pulse, IDLE.
//           JUMP -> apply loop rule, then FETCH.
//           END -> done pulse, IDLE.
//           Illegal opcode -> err=1, done pulse, IDLE.
//   ISSUE   instrc_valid=1 for exactly one cycle; instrcution latched from table word; pc++ -> WAIT.
//   WAIT    desc_gen_last is ignored for 2 cycles after ISSUE, covering its clear latency.
//           Then desc_gen_last=1 -> FETCH, or IDLE with done pulse if abort is pending.
//  Loop rule at JUMP:
//   N=0: jump forever, until abort.
//   loop_cnt==0: load loop_cnt=N-1 and pc=target; if N==1, fall through (pc++).
//   loop_cnt>0: loop_cnt--, pc=target.
//   loop_cnt==0 after reload: pc++.
//  One loop level only: a JUMP with a different target while loop_cnt!=0 -> err=1, IDLE.
//  pc wraps past DEPTH-1 without END -> err=1, done pulse, IDLE.
//  abort in IDLE: ignored.
//   In FETCH/DECODE: -> IDLE next cycle with done pulse.
//   In ISSUE/WAIT: latched as pending, taken at WAIT exit.
//   Simultaneous with start: abort wins.
//  start while busy: ignored.
//  busy=1 in every state except IDLE.
//  Host table writes are allowed at any time; writes during a run take effect on the next fetch of that entry.
//  Issue latency: start to instrc_valid = 3 cycles.
//  Back-to-back PLAYs: desc_gen_last seen to next instrc_valid = 3 cycles.
// CONFIGURATION
//  AWG_SEQ_EXT_TRIG_EN defined:
//   Adds port trig_in (in, 1).
//   A PLAY reaching ISSUE waits in a TRIG_WAIT state until trig_in=1; trig_in is a level, sampled per PLAY.
//   abort in TRIG_WAIT -> IDLE immediately with done pulse.
//  Not defined: no trig_in port, no TRIG_WAIT state; ISSUE follows DECODE directly.
// STRUCTURE
//  Package awg_seq_pkg:
//   Opcode constants OP_PLAY/OP_JUMP/OP_END.
//   Field bit-range constants: addr, length, seg_times, jmp_target, jmp_count.
//   FSM state encoding localparams.
//  Sub-module awg_seq_tbl_ram: simple dual-port RAM, DEPTH x 128.
//   Write port: host.
//   Read port: pc, registered output, 1-cycle latency.
// TESTING
//  1. PLAY(seg=1) @0, END @1; start -> one instrc_valid exactly 3 cycles after start with instrcution==tbl[0];
//     model desc_gen_last -> done pulse; busy falls.
//  2. PLAY@0, PLAY@1, JUMP(target=0, N=3)@2, END@3 -> 6 issues in order 0,1,0,1,0,1, then done; err=0.
//  3. PLAY@0, JUMP(target=0, N=0)@1; abort asserted during WAIT of the 5th issue
//     -> no 6th issue; done 1 cycle after desc_gen_last; busy=0.
//  4. Opcode 0xF @0 -> err=1 and done within 3 cycles, no instrc_valid; a following start clears err.
//  5. Reset asserted mid-WAIT -> all outputs 0 asynchronously; after release, start replays from entry 0.
//  6. With AWG_SEQ_EXT_TRIG_EN: trig_in held 0 -> no issue for 100 cycles;
//     trig_in=1 -> instrc_valid on the following cycle.

Source files
------------

// File: rtl/awg_seq_pkg.sv
// Shared opcodes, instruction field positions and FSM states for the AWG sequencer.
// The TRIG_WAIT state only exists when AWG_SEQ_EXT_TRIG_EN is defined.
package awg_seq_pkg;

    localparam logic [3:0] OP_PLAY = 4'd1;
    localparam logic [3:0] OP_JUMP = 4'd2;
    localparam logic [3:0] OP_END  = 4'd3;

    localparam int OP_HI   = 3;
    localparam int OP_LO   = 0;
    localparam int ADDR_HI = 96;
    localparam int ADDR_LO = 64;
    localparam int LEN_HI  = 57;
    localparam int LEN_LO  = 32;
    localparam int SEG_HI  = 19;
    localparam int SEG_LO  = 4;
    localparam int TGT_HI  = 43;
    localparam int TGT_LO  = 32;
    localparam int CNT_HI  = 19;
    localparam int CNT_LO  = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_ISSUE     = 3'd3,
`ifdef AWG_SEQ_EXT_TRIG_EN
        S_TRIG_WAIT = 3'd5,
`endif
        S_WAIT      = 3'd4
    } state_t;

endpackage

// File: rtl/awg_instr_sequencer_if.sv
// Host table/control and descriptor_generator signals of the AWG sequencer.
// trig_in is present only when AWG_SEQ_EXT_TRIG_EN is defined.
interface awg_instr_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              tbl_wr_en;
    logic [ADDR_W-1:0] tbl_wr_addr;
    logic [127:0]      tbl_wr_data;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              err;
    logic [127:0]      instrcution;
    logic              instrc_valid;
    logic              generate_done;
    logic              desc_gen_last;
`ifdef AWG_SEQ_EXT_TRIG_EN
    logic              trig_in;
`endif

    modport slave (
        input  tbl_wr_en, tbl_wr_addr, tbl_wr_data,
        input  start, abort, generate_done, desc_gen_last,
`ifdef AWG_SEQ_EXT_TRIG_EN
        input  trig_in,
`endif
        output busy, done, err, instrcution, instrc_valid
    );

    modport master (
        output tbl_wr_en, tbl_wr_addr, tbl_wr_data,
        output start, abort, generate_done, desc_gen_last,
`ifdef AWG_SEQ_EXT_TRIG_EN
        output trig_in,
`endif
        input  busy, done, err, instrcution, instrc_valid
    );

endinterface

// File: rtl/awg_seq_tbl_ram.sv
// Instruction table: host write port, registered read port (1-cycle latency).
module awg_seq_tbl_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [127:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [127:0]      rdata
);

    logic [127:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/awg_instr_sequencer.sv
// Walks the instruction table, issues PLAY entries, handles one loop level.
// AWG_SEQ_EXT_TRIG_EN gates each PLAY issue on the trig_in level.
module awg_instr_sequencer
    import awg_seq_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input logic                  clk,
    input logic                  rstn,
    awg_instr_sequencer_if.slave bus
);

    state_t            st, st_n;
    logic [ADDR_W:0]   pc, pc_n;
    logic [15:0]       loop_cnt, cnt_n;
    logic [ADDR_W-1:0] loop_tgt, tgt_n;
    logic [1:0]        wait_cnt, wcnt_n;
    logic              abort_pend, abt_n;
    logic              err_n, done_n, vld_n;
    logic [127:0]      ins_n, rdata;
    logic [3:0]        op;
    logic [15:0]       seg, rpt;
    logic [ADDR_W-1:0] jtgt;
    logic              is_play, is_jump, is_end;
    logic              unused_gen_done;

    awg_seq_tbl_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_tbl (
        .clk   (clk),
        .we    (bus.tbl_wr_en),
        .waddr (bus.tbl_wr_addr),
        .wdata (bus.tbl_wr_data),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (rdata)
    );

    assign op      = rdata[OP_HI:OP_LO];
    assign seg     = rdata[SEG_HI:SEG_LO];
    assign rpt     = rdata[CNT_HI:CNT_LO];
    assign jtgt    = rdata[TGT_LO +: ADDR_W];
    assign is_play = (op == OP_PLAY);
    assign is_jump = (op == OP_JUMP);
    assign is_end  = (op == OP_END);
    assign bus.busy = (st != S_IDLE);
    assign unused_gen_done = bus.generate_done;

    always_comb begin
        st_n   = st;
        pc_n   = pc;
        cnt_n  = loop_cnt;
        tgt_n  = loop_tgt;
        wcnt_n = wait_cnt;
        abt_n  = abort_pend;
        err_n  = bus.err;
        done_n = 1'b0;
        vld_n  = 1'b0;
        ins_n  = bus.instrcution;
        unique case (st)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    st_n  = S_FETCH;
                    pc_n  = '0;
                    cnt_n = '0;
                    abt_n = 1'b0;
                    err_n = 1'b0;
                end
            end
            S_FETCH: begin
                // pc[ADDR_W] set means the walk ran past the last entry
                if (bus.abort) begin
                    st_n   = S_IDLE;
                    done_n = 1'b1;
                end else if (pc[ADDR_W]) begin
                    st_n   = S_IDLE;
                    done_n = 1'b1;
                    err_n  = 1'b1;
                end else begin
                    st_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.abort) begin
                    st_n   = S_IDLE;
                    done_n = 1'b1;
                end else begin
                    unique case (1'b1)
                        is_play: begin
                            if (seg == '0) begin
                                st_n   = S_IDLE;
                                done_n = 1'b1;
                                err_n  = 1'b1;
                            end else begin
`ifdef AWG_SEQ_EXT_TRIG_EN
                                st_n  = S_TRIG_WAIT;
`else
                                st_n  = S_ISSUE;
                                vld_n = 1'b1;
                                ins_n = rdata;
`endif
                            end
                        end
                        is_jump: begin
                            // loop_cnt counts jumps still owed; 0 = no loop
                            st_n = S_FETCH;
                            if (rpt == '0) begin
                                pc_n = {1'b0, jtgt};
                            end else if (loop_cnt == '0) begin
                                cnt_n = rpt - 16'd1;
                                tgt_n = jtgt;
                                pc_n  = (rpt == 16'd1) ? pc + 1'b1
                                                       : {1'b0, jtgt};
                            end else if (jtgt != loop_tgt) begin
                                st_n   = S_IDLE;
                                done_n = 1'b1;
                                err_n  = 1'b1;
                            end else begin
                                cnt_n = loop_cnt - 16'd1;
                                pc_n  = (loop_cnt == 16'd1) ? pc + 1'b1
                                                            : {1'b0, jtgt};
                            end
                        end
                        is_end: begin
                            st_n   = S_IDLE;
                            done_n = 1'b1;
                        end
                        default: begin
                            st_n   = S_IDLE;
                            done_n = 1'b1;
                            err_n  = 1'b1;
                        end
                    endcase
                end
            end
`ifdef AWG_SEQ_EXT_TRIG_EN
            S_TRIG_WAIT: begin
                if (bus.abort) begin
                    st_n   = S_IDLE;
                    done_n = 1'b1;
                end else if (bus.trig_in) begin
                    st_n  = S_ISSUE;
                    vld_n = 1'b1;
                    ins_n = rdata;
                end
            end
`endif
            S_ISSUE: begin
                st_n   = S_WAIT;
                pc_n   = pc + 1'b1;
                wcnt_n = 2'd2;
                if (bus.abort) abt_n = 1'b1;
            end
            S_WAIT: begin
                // desc_gen_last is stale for two cycles after an issue
                if (bus.abort) abt_n = 1'b1;
                if (wait_cnt != '0) begin
                    wcnt_n = wait_cnt - 2'd1;
                end else if (bus.desc_gen_last) begin
                    if (abt_n) begin
                        st_n   = S_IDLE;
                        done_n = 1'b1;
                    end else begin
                        st_n = S_FETCH;
                    end
                end
            end
            default: st_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st               <= S_IDLE;
            pc               <= '0;
            loop_cnt         <= '0;
            loop_tgt         <= '0;
            wait_cnt         <= '0;
            abort_pend       <= 1'b0;
            bus.err          <= 1'b0;
            bus.done         <= 1'b0;
            bus.instrc_valid <= 1'b0;
            bus.instrcution  <= '0;
        end else begin
            st               <= st_n;
            pc               <= pc_n;
            loop_cnt         <= cnt_n;
            loop_tgt         <= tgt_n;
            wait_cnt         <= wcnt_n;
            abort_pend       <= abt_n;
            bus.err          <= err_n;
            bus.done         <= done_n;
            bus.instrc_valid <= vld_n;
            bus.instrcution  <= ins_n;
        end
    end

endmodule

// File: tb/tb_awg_instr_sequencer.sv
// Bench for awg_instr_sequencer: directed programs with random fields,
// checked against a program-level interpreter of the instruction table.
module tb_awg_instr_sequencer;
    import awg_seq_pkg::*;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
`ifdef AWG_SEQ_EXT_TRIG_EN
    localparam int TRIG_X = 1;
`else
    localparam int TRIG_X = 0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    awg_instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    awg_instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [127:0] tbl [DEPTH];
    logic [127:0] exp_q [$];
    int           exp_gap [$];
    int           exp_end_gap;
    bit           exp_err;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] play(input logic [15:0] seg);
        logic [127:0] w;
        w = '0;
        w[OP_HI:OP_LO]     = OP_PLAY;
        w[ADDR_HI:ADDR_LO] = {1'($urandom), $urandom};
        w[LEN_HI:LEN_LO]   = 26'($urandom);
        w[SEG_HI:SEG_LO]   = seg;
        return w;
    endfunction

    function automatic logic [127:0] jump(input int tgt, input int n);
        logic [127:0] w;
        w = '0;
        w[OP_HI:OP_LO]   = OP_JUMP;
        w[TGT_HI:TGT_LO] = 12'(tgt);
        w[CNT_HI:CNT_LO] = 16'(n);
        return w;
    endfunction

    function automatic logic [127:0] endw();
        logic [127:0] w;
        w = '0;
        w[OP_HI:OP_LO] = OP_END;
        return w;
    endfunction

    // Interprets the table: a JUMP with N>0 runs its body N times in total.
    // Each fetched instruction costs 2 cycles; gaps are measured from start
    // or from the last desc_gen_last rise.
    function automatic void model();
        int pc, hits, ltgt, j, n, t;
        logic [127:0] w;
        pc = 0; hits = 0; ltgt = 0; j = 0;
        exp_q.delete();
        exp_gap.delete();
        exp_err = 1'b0;
        exp_end_gap = 0;
        for (int step = 0; step < 2000; step++) begin
            if (pc >= DEPTH) begin
                exp_err = 1'b1; exp_end_gap = 2 + 2 * j; return;
            end
            w = tbl[pc];
            n = int'(w[CNT_HI:CNT_LO]);
            t = int'(w[TGT_LO+ADDR_W-1:TGT_LO]);
            case (w[OP_HI:OP_LO])
                OP_PLAY: begin
                    if (w[SEG_HI:SEG_LO] == 16'd0) begin
                        exp_err = 1'b1; exp_end_gap = 3 + 2 * j; return;
                    end
                    exp_q.push_back(w);
                    exp_gap.push_back(3 + 2 * j + TRIG_X);
                    j = 0;
                    pc++;
                    if (exp_q.size() >= 64) return;
                end
                OP_JUMP: begin
                    if (n == 0) begin
                        pc = t; j++;
                    end else if (hits > 0 && t != ltgt) begin
                        exp_err = 1'b1; exp_end_gap = 3 + 2 * j; return;
                    end else begin
                        ltgt = t; hits++; j++;
                        if (hits < n) pc = t;
                        else begin hits = 0; pc++; end
                    end
                end
                OP_END: begin exp_end_gap = 3 + 2 * j; return; end
                default: begin
                    exp_err = 1'b1; exp_end_gap = 3 + 2 * j; return;
                end
            endcase
        end
    endfunction

    task automatic wr(input int a, input logic [127:0] d);
        @(negedge clk);
        bus.tbl_wr_en   = 1'b1;
        bus.tbl_wr_addr = 8'(a);
        bus.tbl_wr_data = d;
        tbl[a] = d;
        @(negedge clk);
        bus.tbl_wr_en = 1'b0;
    endtask

    // Runs the current program acting as descriptor_generator.
    // abort_issue>0: abort in WAIT after that issue; abort_cyc>=0: abort then.
    task automatic run(input string tag, input int abort_issue,
                       input int abort_cyc);
        int cyc, nv, ref_c, dgl_at, ab_at, done_at, extra, n_exp, gap;
        bit e;
        cyc = 0; nv = 0; ref_c = 0; dgl_at = -1;
        ab_at = abort_cyc; done_at = -1; extra = 0;
        model();
        n_exp = (abort_issue > 0) ? abort_issue :
                (abort_cyc >= 0) ? 0 : exp_q.size();
        e = (abort_issue > 0 || abort_cyc >= 0) ? 1'b0 : exp_err;
        @(negedge clk);
        bus.start = 1'b1;
        while (done_at < 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            bus.generate_done = 1'b0;
            if (cyc == 1) begin
                chk({tag, " err_clear"}, bus.err, 0);
                chk({tag, " busy"}, bus.busy, 1);
            end
            if (bus.instrc_valid) begin
                if (nv < n_exp) begin
                    chk({tag, " word"}, bus.instrcution, exp_q[nv]);
                    chk({tag, " issue_gap"}, cyc - ref_c, exp_gap[nv]);
                end else begin
                    chk({tag, " extra_issue"}, nv + 1, n_exp);
                end
                nv++;
                bus.desc_gen_last = 1'b0;
                dgl_at = cyc + int'($urandom_range(3, 8));
                if (nv == abort_issue) ab_at = cyc + 1;
            end
            if (cyc == ab_at) bus.abort = 1'b1;
            if (cyc == dgl_at - 1) bus.generate_done = 1'b1;
            if (cyc == dgl_at) begin
                bus.desc_gen_last = 1'b1;
                ref_c = cyc;
            end
            if (bus.done) done_at = cyc;
        end
        chk({tag, " done_seen"}, done_at >= 0, 1);
        chk({tag, " issues"}, nv, n_exp);
        chk({tag, " err"}, bus.err, e);
        chk({tag, " busy_low"}, bus.busy, 0);
        if (abort_cyc >= 0) gap = done_at - abort_cyc;
        else gap = done_at - ref_c;
        chk({tag, " done_gap"}, gap,
            (abort_issue > 0 || abort_cyc >= 0) ? 1 : exp_end_gap);
        repeat (12) begin
            @(negedge clk);
            extra += int'(bus.instrc_valid) + int'(bus.done);
        end
        chk({tag, " quiet"}, extra, 0);
    endtask

    initial begin
        int k;
        bus.tbl_wr_en     = 1'b0;
        bus.tbl_wr_addr   = '0;
        bus.tbl_wr_data   = '0;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.generate_done = 1'b0;
        bus.desc_gen_last = 1'b1;
`ifdef AWG_SEQ_EXT_TRIG_EN
        bus.trig_in       = 1'b1;
`endif
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst err", bus.err, 0);
        chk("rst valid", bus.instrc_valid, 0);
        chk("rst instr", bus.instrcution, 0);
        rstn = 1'b1;

        for (int i = 0; i < DEPTH; i++) wr(i, endw());

        wr(0, play(16'd1)); wr(1, endw());
        run("single", 0, -1);

        wr(0, play(16'($urandom_range(1, 65535))));
        wr(1, play(16'($urandom_range(1, 65535))));
        wr(2, jump(0, 3)); wr(3, endw());
        run("loop3", 0, -1);

        wr(0, play(16'($urandom_range(1, 65535))));
        wr(1, jump(0, 0));
        run("forever_abort", 5, -1);

        wr(0, {$urandom, $urandom, $urandom, 28'($urandom), 4'hF});
        run("illegal", 0, -1);
        wr(0, play(16'($urandom_range(1, 65535)))); wr(1, endw());
        run("after_err", 0, -1);

        wr(0, play(16'd0));
        run("seg_zero", 0, -1);

        wr(0, play(16'($urandom_range(1, 65535)))); wr(1, jump(0, 1));
        wr(2, play(16'hFFFF)); wr(3, endw());
        run("n_one", 0, -1);

        wr(0, play(16'd5)); wr(1, jump(3, 2)); wr(2, endw());
        wr(3, play(16'd7)); wr(4, jump(0, 2));
        run("nest_err", 0, -1);

        wr(0, play(16'd3)); wr(1, endw());
        run("abort_fetch", 0, 1);
        run("abort_decode", 0, 2);

        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort busy", bus.busy, 0);
        @(negedge clk);
        chk("start_abort valid", bus.instrc_valid, 0);

        for (int r = 0; r < 4; r++) begin
            k = int'($urandom_range(1, 3));
            for (int i = 0; i < k; i++)
                wr(i, play(16'($urandom_range(1, 65535))));
            wr(k, jump(int'($urandom_range(0, k - 1)),
                       int'($urandom_range(1, 4))));
            wr(k + 1, play(16'($urandom_range(1, 65535))));
            wr(k + 2, endw());
            run("random", 0, -1);
        end

        wr(0, play(16'd9)); wr(1, play(16'd4)); wr(2, endw());
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.instrc_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rstwait issue", bus.instrc_valid, 1);
        bus.desc_gen_last = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async busy", bus.busy, 0);
        chk("async done", bus.done, 0);
        chk("async err", bus.err, 0);
        chk("async valid", bus.instrc_valid, 0);
        chk("async instr", bus.instrcution, 0);
        @(negedge clk);
        rstn = 1'b1;
        bus.desc_gen_last = 1'b1;
        run("replay", 0, -1);

`ifdef AWG_SEQ_EXT_TRIG_EN
        wr(0, play(16'd2)); wr(1, endw());
        bus.trig_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        repeat (100) begin
            @(negedge clk);
            k += int'(bus.instrc_valid);
        end
        chk("trig hold", k, 0);
        chk("trig busy", bus.busy, 1);
        bus.trig_in = 1'b1;
        @(negedge clk);
        chk("trig issue", bus.instrc_valid, 1);
        chk("trig word", bus.instrcution, tbl[0]);
        bus.desc_gen_last = 1'b0;
        repeat (3) @(negedge clk);
        bus.desc_gen_last = 1'b1;
        k = 0;
        while (!bus.done && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("trig done", bus.done, 1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
